// File: rtl/present_enc_core.sv
// present_enc_core: iterative PRESENT-80 encryption, one round per clock.
// Accept -> 31 rounds -> K32 whitening -> DONE. out_valid rises 32 cycles
// after the accept edge and holds until out_ready.
// Build option: define PRESENT_KEY128_EN for the 128-bit key schedule
// (KW=128); undefined gives the 80-bit schedule (KW=80).

// 4-bit PRESENT forward S-box.
module present_sbox (
  input  logic [3:0] a,
  output logic [3:0] y
);
  // Forward substitution table
  always_comb begin
    case (a)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
  end
endmodule

module present_enc_core #(
  parameter bit ZERO_ON_IDLE = 1'b0,
`ifdef PRESENT_KEY128_EN
  localparam int KW = 128
`else
  localparam int KW = 80
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic [KW-1:0] in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    fsm;
  logic [63:0]   state;
  logic [KW-1:0] keyreg;
  logic [4:0]    rnd;
  logic          fin;      // round 31 done; next RUN edge is whitening
  logic [63:0]   out_reg;
  logic          out_vld;

  logic [63:0]   ark;      // state ^ round key
  logic [63:0]   sl;       // after S-layer
  logic [63:0]   pl;       // after P-layer
  logic [KW-1:0] krot;
  logic [KW-1:0] knext;

  assign ark = state ^ keyreg[KW-1 -: 64];

  // 16 parallel state S-boxes
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present_sbox u_sbox (.a(ark[4*g +: 4]), .y(sl[4*g +: 4]));
  end

  // Bit permutation: bit i -> 16*i mod 63, bit 63 fixed
  for (genvar i = 0; i < 64; i++) begin : g_perm
    localparam int DST = (i == 63) ? 63 : (16 * i) % 63;
    assign pl[DST] = sl[i];
  end

`ifdef PRESENT_KEY128_EN
  logic [3:0] ks_hi, ks_lo;
  assign krot = {keyreg[66:0], keyreg[127:67]};   // rotate left 61
  present_sbox u_ks_hi (.a(krot[127:124]), .y(ks_hi));
  present_sbox u_ks_lo (.a(krot[123:120]), .y(ks_lo));
  assign knext = {ks_hi, ks_lo, krot[119:67], krot[66:62] ^ rnd, krot[61:0]};
`else
  logic [3:0] ks_hi;
  assign krot = {keyreg[18:0], keyreg[79:19]};    // rotate left 61
  present_sbox u_ks_hi (.a(krot[79:76]), .y(ks_hi));
  assign knext = {ks_hi, krot[75:20], krot[19:15] ^ rnd, krot[14:0]};
`endif

  // Control FSM plus round datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      state   <= '0;
      keyreg  <= '0;
      rnd     <= '0;
      fin     <= 1'b0;
      out_reg <= '0;
      out_vld <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state  <= in_data;
            keyreg <= in_key;
            rnd    <= 5'd1;
            fin    <= 1'b0;
            fsm    <= RUN;
          end
        end
        RUN: begin
          if (fin) begin
            out_reg <= ark;           // K32 whitening
            out_vld <= 1'b1;
            fin     <= 1'b0;
            fsm     <= DONE;
          end else begin
            state  <= pl;
            keyreg <= knext;
            // counter parks at 31 instead of wrapping; fin marks the end
            if (rnd == 5'd31) fin <= 1'b1;
            else              rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_vld <= 1'b0;
            fsm     <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = out_vld;
  assign out_data  = (ZERO_ON_IDLE && !out_vld) ? 64'd0 : out_reg;

endmodule

// File: tb/tb_present_enc_core.sv
// Bench for present_enc_core: known-answer vectors, randomized requests
// against a loop-based PRESENT model, backpressure, mid-run reset, and a
// second instance built with ZERO_ON_IDLE=1.
module tb_present_enc_core;

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   in_data = '0;
  logic [KW-1:0] in_key = '0;
  logic          in_ready, out_valid, in_ready_z, out_valid_z;
  logic [63:0]   out_data, out_data_z;

  int n_tests = 0;
  int n_fail  = 0;

  present_enc_core #(.ZERO_ON_IDLE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  present_enc_core #(.ZERO_ON_IDLE(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid_z),
    .out_ready(out_ready), .out_data(out_data_z));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Whole-cipher reference: 31 rounds then whitening, straight from the algorithm.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [KW-1:0] key);
    logic [63:0]   s, t;
    logic [KW-1:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[KW-1 -: 64];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = SB[s[n*4 +: 4]];
      s = '0;
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      k = (k << 61) | (k >> (KW - 61));
      k[KW-1 -: 4] = SB[k[KW-1 -: 4]];
`ifdef PRESENT_KEY128_EN
      k[KW-5 -: 4] = SB[k[KW-5 -: 4]];
      k[66:62] = k[66:62] ^ 5'(r);
`else
      k[19:15] = k[19:15] ^ 5'(r);
`endif
    end
    return s ^ k[KW-1 -: 64];
  endfunction

  // One full request: accept, wait for result, optional backpressure, release.
  task automatic do_enc(input logic [63:0] pt, input logic [KW-1:0] key,
                        input logic [63:0] exp, input int hold);
    int lat;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    chk("run_in_ready", 64'(in_ready), 64'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (lat == 10) chk("zero_on_idle_run", out_data_z, 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd32);
    chk("ciphertext", out_data, exp);
    chk("ciphertext_z", out_data_z, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = (h == 2);               // stray request while busy
      in_data  = ~pt;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_data", out_data, exp);
      chk("hold_valid_ready", {out_valid, in_ready}, 64'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_data_kept", out_data, exp);
    chk("release_data_z", out_data_z, 64'd0);
  endtask

  logic [127:0]  rnd_key;
  logic [63:0]   rnd_pt;
  logic [KW-1:0] ones;
  logic [KW-1:0] zk;

  initial begin
    ones = '1;
    zk   = '0;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PRESENT_KEY128_EN
    do_enc(64'h0, zk, 64'h96DB702A2E6900AF, 0);
    do_enc(64'hFFFFFFFFFFFFFFFF, ones, ref_enc(64'hFFFFFFFFFFFFFFFF, ones), 10);
`else
    do_enc(64'h0, zk, 64'h5579C1387B228445, 0);
    do_enc(64'hFFFFFFFFFFFFFFFF, ones, 64'h3333DCD3213210D2, 10);
    do_enc(64'h0, ones, 64'hE72C46C0F5945049, 0);
`endif

    // Reset in the middle of a run: partial result must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'h0123456789ABCDEF;
    in_key   = ones;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_data", out_data, 64'd0);
    chk("midreset_out_data_z", out_data_z, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef PRESENT_KEY128_EN
    do_enc(64'hFFFFFFFFFFFFFFFF, zk, ref_enc(64'hFFFFFFFFFFFFFFFF, zk), 0);
`else
    do_enc(64'hFFFFFFFFFFFFFFFF, zk, 64'hA112FFC72F68417B, 0);
`endif

    for (int t = 0; t < 8; t++) begin
      rnd_key = {$urandom, $urandom, $urandom, $urandom};
      rnd_pt  = {$urandom, $urandom};
      do_enc(rnd_pt, rnd_key[KW-1:0], ref_enc(rnd_pt, rnd_key[KW-1:0]),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
